pc_gen: RTL and testbench

Parametrised program-counter generator for the IF stage of the pipelined core; the successor to the plain stall-able PC register. It holds the fetch address and chooses the next PC from four sources, in priority order: trap entry, branch/jump redirect, pending (deferred) redirect, sequential increment. It defers redirects that arrive during a stall, detects misaligned targets, and supports a halt/resume mode for debug.

---
 rtl/pc_gen.sv | 111 +++++++++++
 tb/tb_pc_gen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Program-counter generator for the IF stage: picks the next fetch address from trap, redirect,
// deferred redirect or sequential step, with misaligned-target detection and debug halt/resume.
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned     STEP         = 4,
  parameter int unsigned     ALIGN_LSB    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write_en,
  input  logic            trap_req,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] current_pc,
  output logic            fetch_valid,
  output logic            misaligned_fault,
  output logic [XLEN-1:0] fault_addr,
  output logic            pending_valid
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  // Mask of target bits that must be zero; empty when ALIGN_LSB is 0.
  localparam logic [XLEN-1:0] AlignMask = (XLEN'(1) << ALIGN_LSB) - XLEN'(1);
  localparam logic [XLEN-1:0] StepInc   = XLEN'(STEP);

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pend_target_q;
  logic            pend_valid_q;
  logic            fetch_valid_q;
  logic            fault_q;
  logic [XLEN-1:0] fault_addr_q;
  logic            target_misaligned;

  assign target_misaligned = |(redirect_target & AlignMask);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StBoot;
      pc_q          <= RESET_VECTOR;
      pend_target_q <= '0;
      pend_valid_q  <= 1'b0;
      fetch_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      fault_addr_q  <= '0;
    end else begin
      fault_q <= 1'b0;
      case (state_q)
        StBoot: begin
          state_q       <= StRun;
          fetch_valid_q <= 1'b1;
        end
        StRun: begin
          if (halt_req && !trap_req) begin
            state_q       <= StHalt;
            fetch_valid_q <= 1'b0;
          end
          if (trap_req) begin
            pc_q         <= TRAP_VECTOR;
            pend_valid_q <= 1'b0;
          end else if (redirect_valid && target_misaligned) begin
            pc_q         <= TRAP_VECTOR;
            fault_q      <= 1'b1;
            fault_addr_q <= redirect_target;
            pend_valid_q <= 1'b0;
          end else if (redirect_valid && pc_write_en) begin
            pc_q <= redirect_target;
          end else if (redirect_valid) begin
            // Only the first redirect seen during a stall is kept: it is the older instruction.
            if (!pend_valid_q) begin
              pend_target_q <= redirect_target;
              pend_valid_q  <= 1'b1;
            end
          end else if (pend_valid_q && pc_write_en) begin
            pc_q         <= pend_target_q;
            pend_valid_q <= 1'b0;
          end else if (pc_write_en) begin
            pc_q <= pc_q + StepInc;
          end
        end
        StHalt: begin
          if (trap_req) begin
            state_q       <= StRun;
            fetch_valid_q <= 1'b1;
            pc_q          <= TRAP_VECTOR;
            pend_valid_q  <= 1'b0;
          end else if (resume) begin
            state_q       <= StRun;
            fetch_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q       <= StBoot;
          fetch_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign current_pc       = pc_q;
  assign fetch_valid      = fetch_valid_q;
  assign misaligned_fault = fault_q;
  assign fault_addr       = fault_addr_q;
  assign pending_valid    = pend_valid_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: two instances share stimulus, one with 4-byte and one with
// 2-byte target alignment.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write_en;
  logic        trap_req;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt_req;
  logic        resume;

  logic [31:0] pc_a, fa_a, pc_b, fa_b;
  logic        fv_a, mf_a, pv_a, fv_b, mf_b, pv_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_gen #(.ALIGN_LSB(2)) u_dut_a (
    .clk(clk), .rst(rst), .pc_write_en(pc_write_en), .trap_req(trap_req),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halt_req(halt_req), .resume(resume), .current_pc(pc_a), .fetch_valid(fv_a),
    .misaligned_fault(mf_a), .fault_addr(fa_a), .pending_valid(pv_a)
  );

  pc_gen #(.ALIGN_LSB(1)) u_dut_b (
    .clk(clk), .rst(rst), .pc_write_en(pc_write_en), .trap_req(trap_req),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halt_req(halt_req), .resume(resume), .current_pc(pc_b), .fetch_valid(fv_b),
    .misaligned_fault(mf_b), .fault_addr(fa_b), .pending_valid(pv_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; pc_write_en = 1'b1;
    tick(); tick();
    checks++; if (pc_a !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc_a, 32'h0); end
    checks++; if (fv_a !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b expected 0", fv_a); end
    checks++; if (pv_a !== 1'b0) begin errors++; $display("FAIL reset_pend: got %b expected 0", pv_a); end
    checks++; if (mf_a !== 1'b0 || fa_a !== 32'h0) begin
      errors++; $display("FAIL reset_fault: got %b/%h expected 0/00000000", mf_a, fa_a);
    end
    rst = 1'b1;
    tick();
    checks++; if (pc_a !== 32'h0 || fv_a !== 1'b1) begin
      errors++; $display("FAIL boot_exit: got pc %h fv %b expected 00000000 1", pc_a, fv_a);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (pc_a !== 32'(4 * i) || fv_a !== 1'b1) begin
        errors++; $display("FAIL step_%0d: got pc %h fv %b expected %h 1", i, pc_a, fv_a, 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall_deferred();
    // PC is 0x10 here.
    pc_write_en = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h200;
    tick();
    checks++; if (pc_a !== 32'h10 || pv_a !== 1'b1) begin
      errors++; $display("FAIL defer_first: got pc %h pend %b expected 00000010 1", pc_a, pv_a);
    end
    redirect_target = 32'h300;
    tick();
    checks++; if (pc_a !== 32'h10 || pv_a !== 1'b1) begin
      errors++; $display("FAIL defer_second: got pc %h pend %b expected 00000010 1", pc_a, pv_a);
    end
    redirect_valid = 1'b0;
    tick();
    checks++; if (pc_a !== 32'h10) begin errors++; $display("FAIL defer_hold: got %h expected 00000010", pc_a); end
    pc_write_en = 1'b1;
    tick();
    checks++; if (pc_a !== 32'h200 || pv_a !== 1'b0) begin
      errors++; $display("FAIL defer_apply: got pc %h pend %b expected 00000200 0", pc_a, pv_a);
    end
    tick();
    checks++; if (pc_a !== 32'h204) begin errors++; $display("FAIL defer_next: got %h expected 00000204", pc_a); end
  endtask

  task automatic test_trap_priority();
    pc_write_en = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h40;
    tick();
    checks++; if (pv_a !== 1'b1) begin errors++; $display("FAIL trap_setup_pend: got %b expected 1", pv_a); end
    trap_req = 1'b1; redirect_target = 32'h80;
    tick();
    checks++; if (pc_a !== 32'h100 || pv_a !== 1'b0) begin
      errors++; $display("FAIL trap_pc: got pc %h pend %b expected 00000100 0", pc_a, pv_a);
    end
    trap_req = 1'b0; redirect_valid = 1'b0; pc_write_en = 1'b1;
    tick();
    checks++; if (pc_a !== 32'h104) begin errors++; $display("FAIL trap_after: got %h expected 00000104", pc_a); end
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1; redirect_target = 32'h202; pc_write_en = 1'b1;
    tick();
    checks++; if (pc_a !== 32'h100) begin errors++; $display("FAIL misal_pc: got %h expected 00000100", pc_a); end
    checks++; if (mf_a !== 1'b1 || fa_a !== 32'h202) begin
      errors++; $display("FAIL misal_fault: got %b/%h expected 1/00000202", mf_a, fa_a);
    end
    checks++; if (pc_b !== 32'h202 || mf_b !== 1'b0) begin
      errors++; $display("FAIL align1_pc: got pc %h fault %b expected 00000202 0", pc_b, mf_b);
    end
    redirect_valid = 1'b0; pc_write_en = 1'b0;
    tick();
    checks++; if (mf_a !== 1'b0 || fa_a !== 32'h202) begin
      errors++; $display("FAIL misal_pulse: got %b/%h expected 0/00000202", mf_a, fa_a);
    end
    // Misaligned target while stalled still traps on the 2-byte instance.
    redirect_valid = 1'b1; redirect_target = 32'h301;
    tick();
    checks++; if (pc_b !== 32'h100 || mf_b !== 1'b1 || fa_b !== 32'h301) begin
      errors++; $display("FAIL align1_stall_fault: got pc %h fault %b addr %h expected 00000100 1 00000301",
                         pc_b, mf_b, fa_b);
    end
    redirect_valid = 1'b0;
    tick();
  endtask

  task automatic test_wrap_halt();
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC; pc_write_en = 1'b1;
    tick();
    checks++; if (pc_a !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup: got %h expected fffffffc", pc_a); end
    redirect_valid = 1'b0;
    tick();
    checks++; if (pc_a !== 32'h0 || mf_a !== 1'b0) begin
      errors++; $display("FAIL wrap: got pc %h fault %b expected 00000000 0", pc_a, mf_a);
    end
    tick();
    halt_req = 1'b1;
    tick();
    checks++; if (pc_a !== 32'h8 || fv_a !== 1'b0) begin
      errors++; $display("FAIL halt_enter: got pc %h fv %b expected 00000008 0", pc_a, fv_a);
    end
    halt_req = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h500;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (pc_a !== 32'h8 || fv_a !== 1'b0 || pv_a !== 1'b0) begin
        errors++; $display("FAIL halt_hold_%0d: got pc %h fv %b pend %b expected 00000008 0 0", i, pc_a, fv_a, pv_a);
      end
    end
    redirect_valid = 1'b0; resume = 1'b1;
    tick();
    checks++; if (pc_a !== 32'h8 || fv_a !== 1'b1) begin
      errors++; $display("FAIL resume: got pc %h fv %b expected 00000008 1", pc_a, fv_a);
    end
    resume = 1'b0;
    tick();
    checks++; if (pc_a !== 32'hC) begin errors++; $display("FAIL resume_step: got %h expected 0000000c", pc_a); end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0; trap_req = 1'b1; resume = 1'b1;
    tick();
    checks++; if (pc_a !== 32'h100 || fv_a !== 1'b1) begin
      errors++; $display("FAIL halt_trap: got pc %h fv %b expected 00000100 1", pc_a, fv_a);
    end
    trap_req = 1'b0; resume = 1'b0;
  endtask

  task automatic test_reset_midop();
    pc_write_en = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h600;
    tick();
    redirect_valid = 1'b0; halt_req = 1'b1;
    tick();
    checks++; if (pv_a !== 1'b1 || fv_a !== 1'b0) begin
      errors++; $display("FAIL midop_setup: got pend %b fv %b expected 1 0", pv_a, fv_a);
    end
    rst = 1'b0; halt_req = 1'b0;
    tick();
    checks++; if (pc_a !== 32'h0 || pv_a !== 1'b0 || fv_a !== 1'b0) begin
      errors++; $display("FAIL midop_reset: got pc %h pend %b fv %b expected 00000000 0 0", pc_a, pv_a, fv_a);
    end
    rst = 1'b1; pc_write_en = 1'b1;
    tick();
    checks++; if (pc_a !== 32'h0 || fv_a !== 1'b1) begin
      errors++; $display("FAIL midop_boot: got pc %h fv %b expected 00000000 1", pc_a, fv_a);
    end
    tick();
    checks++; if (pc_a !== 32'h4) begin errors++; $display("FAIL midop_step: got %h expected 00000004", pc_a); end
  endtask

  initial begin
    rst = 1'b0; pc_write_en = 1'b0; trap_req = 1'b0; redirect_valid = 1'b0;
    redirect_target = '0; halt_req = 1'b0; resume = 1'b0;
    test_reset();
    test_stall_deferred();
    test_trap_priority();
    test_misaligned();
    test_wrap_halt();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
